// File: rtl/chad_gstack_if.sv
// chad_gstack_if: control and status bundle for one guarded Chad stack (D or R)
interface chad_gstack_if #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
);
  logic                       hold;
  logic [1:0]                 delta;
  logic                       we;
  logic [WIDTH-1:0]           wd;
  logic                       flush;
  logic                       clr_err;
  logic [WIDTH-1:0]           rd;
  logic [$clog2(DEPTH):0]     depth;
  logic                       empty;
  logic                       full;
  logic                       hiwater;
  logic                       ovf;
  logic                       unf;
  modport master (
    output hold, delta, we, wd, flush, clr_err,
    input  rd, depth, empty, full, hiwater, ovf, unf
  );
  modport slave (
    input  hold, delta, we, wd, flush, clr_err,
    output rd, depth, empty, full, hiwater, ovf, unf
  );
endinterface

// File: rtl/chad_gstack.sv
// chad_gstack: guarded LIFO with wrapping pointer, clamped occupancy and sticky ovf/unf flags
module chad_gstack #(
  parameter int WIDTH   = 18,
  parameter int DEPTH   = 16,
  parameter int HIWATER = 12
) (
  input logic          clk,
  input logic          resetq,
  chad_gstack_if.slave stk
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [AW-1:0]        p, p_n;
  logic [DW-1:0]        dq, d_n;
  logic signed [DW+1:0] s_sum;
  logic                 ovf_q, unf_q, ovf_set, unf_set;
  // occupancy is tracked on a signed sum so both clamp directions are visible
  always_comb begin
    s_sum   = signed'({2'b00, dq}) + (DW+2)'(signed'(stk.delta));
    ovf_set = !stk.flush && (s_sum > DEPTH);
    unf_set = !stk.flush && (s_sum < 0);
    p_n     = stk.flush ? '0 : p + AW'(signed'(stk.delta));
    d_n     = stk.flush ? '0 : ovf_set ? DW'(DEPTH) : unf_set ? '0 : s_sum[DW-1:0];
  end
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      p     <= '0;
      dq    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!stk.hold) begin
      p     <= p_n;
      dq    <= d_n;
      ovf_q <= ovf_set | (ovf_q & !stk.clr_err);
      unf_q <= unf_set | (unf_q & !stk.clr_err);
    end
  always_ff @(posedge clk)
    if (!stk.hold && stk.we) mem[p_n] <= stk.wd;
  assign stk.rd      = mem[p];
  assign stk.depth   = dq;
  assign stk.empty   = dq == '0;
  assign stk.full    = dq == DW'(DEPTH);
  assign stk.hiwater = dq >= DW'(HIWATER);
  assign stk.ovf     = ovf_q;
  assign stk.unf     = unf_q;
endmodule
